// File: rtl/cheri_stkz_lsu_arb.sv
// Arbitrates the core LSU and the stack-zeroization engine onto one data bus.
// Tracks bus-response ownership in a grant-ordered FIFO and routes responses back.
module cheri_stkz_lsu_arb #(
   parameter int unsigned MaxOutstanding = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        stkz_lsu_req_i,
   input  logic        stkz_lsu_we_i,
   input  logic        stkz_lsu_is_cap_i,
   input  logic [31:0] stkz_lsu_addr_i,
   input  logic [32:0] stkz_lsu_wdata_i,
   output logic        lsu_stkz_req_done_o,
   output logic        lsu_stkz_resp_valid_o,
   output logic        lsu_stkz_resp_err_o,
   input  logic        core_req_i,
   input  logic        core_we_i,
   input  logic        core_is_cap_i,
   input  logic [31:0] core_addr_i,
   input  logic [32:0] core_wdata_i,
   output logic        core_gnt_o,
   output logic        core_rvalid_o,
   output logic        core_err_o,
   output logic [32:0] core_rdata_o,
   output logic        data_req_o,
   output logic        data_we_o,
   output logic        data_is_cap_o,
   output logic [31:0] data_addr_o,
   output logic [32:0] data_wdata_o,
   input  logic        data_gnt_i,
   input  logic        data_rvalid_i,
   input  logic        data_err_i,
   input  logic [32:0] data_rdata_i
);

   localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
   localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
   localparam logic [CntW-1:0] CntMax  = CntW'(MaxOutstanding);
   localparam logic [PtrW-1:0] PtrLast = PtrW'(MaxOutstanding - 1);

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_CORE = 2'd1,
      ARB_STKZ = 2'd2
   } arb_state_e;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrLast) ? {PtrW{1'b0}} : p + PtrW'(1);
   endfunction

   arb_state_e              state_r, state_n_s;
   logic                    owner_r, we_r, cap_r;
   logic [31:0]             addr_r;
   logic [32:0]             wdata_r;
   logic [CntW-1:0]         cnt_r;
   logic [PtrW-1:0]         rd_ptr_r, wr_ptr_r;
   logic [MaxOutstanding-1:0] fifo_r;
   logic                    rd_pend_r;

   logic        req_s, owner_s, we_s, cap_s, capture_s, rd_acc_s;
   logic [31:0] addr_s;
   logic [32:0] wdata_s;
   logic        slot_free_s, fifo_empty_s, push_s, pop_s, head_s;

   assign slot_free_s  = (cnt_r < CntMax);
   assign fifo_empty_s = (cnt_r == {CntW{1'b0}});

   // Next-state and bus-request selection; owner bit 1 means stkz.
   always_comb begin
      state_n_s = state_r;
      req_s     = 1'b0;
      owner_s   = 1'b0;
      we_s      = 1'b0;
      cap_s     = 1'b0;
      addr_s    = 32'h0;
      wdata_s   = 33'h0;
      capture_s = 1'b0;
      rd_acc_s  = 1'b0;
      case (state_r)
         ARB_IDLE: begin
            if (slot_free_s && core_req_i) begin
               req_s   = 1'b1;
               owner_s = 1'b0;
               we_s    = core_we_i;
               cap_s   = core_is_cap_i;
               addr_s  = core_addr_i;
               wdata_s = core_wdata_i;
            end else if (slot_free_s && stkz_lsu_req_i && stkz_lsu_we_i) begin
               req_s   = 1'b1;
               owner_s = 1'b1;
               we_s    = 1'b1;
               cap_s   = stkz_lsu_is_cap_i;
               addr_s  = stkz_lsu_addr_i;
               wdata_s = stkz_lsu_wdata_i;
            end else begin
               // Reads are refused locally only with no bus traffic pending, keeping response order.
               rd_acc_s = fifo_empty_s && !core_req_i && stkz_lsu_req_i && !stkz_lsu_we_i;
            end
            if (req_s && !data_gnt_i) begin
               capture_s = 1'b1;
               state_n_s = owner_s ? ARB_STKZ : ARB_CORE;
            end else begin
               state_n_s = ARB_IDLE;
            end
         end
         ARB_CORE, ARB_STKZ: begin
            req_s   = 1'b1;
            owner_s = owner_r;
            we_s    = we_r;
            cap_s   = cap_r;
            addr_s  = addr_r;
            wdata_s = wdata_r;
            if (data_gnt_i) begin
               state_n_s = ARB_IDLE;
            end else begin
               state_n_s = state_r;
            end
         end
         default: begin
            state_n_s = ARB_IDLE;
         end
      endcase
   end

   assign push_s = req_s & data_gnt_i;
   assign pop_s  = data_rvalid_i & ~fifo_empty_s;
   assign head_s = fifo_r[rd_ptr_r];

   assign data_req_o    = req_s;
   assign data_we_o     = we_s;
   assign data_is_cap_o = cap_s;
   assign data_addr_o   = addr_s;
   assign data_wdata_o  = wdata_s;

   assign core_gnt_o            = push_s & ~owner_s;
   assign lsu_stkz_req_done_o   = (push_s & owner_s) | rd_acc_s;
   assign core_rvalid_o         = pop_s & ~head_s;
   assign core_err_o            = pop_s & ~head_s & data_err_i;
   assign core_rdata_o          = core_rvalid_o ? data_rdata_i : 33'h0;
   assign lsu_stkz_resp_valid_o = (pop_s & head_s) | rd_pend_r;
   assign lsu_stkz_resp_err_o   = rd_pend_r | (pop_s & head_s & data_err_i);

   // FSM state and the request held while waiting for grant.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r <= ARB_IDLE;
         owner_r <= 1'b0;
         we_r    <= 1'b0;
         cap_r   <= 1'b0;
         addr_r  <= 32'h0;
         wdata_r <= 33'h0;
      end else begin
         state_r <= state_n_s;
         if (capture_s) begin
            owner_r <= owner_s;
            we_r    <= we_s;
            cap_r   <= cap_s;
            addr_r  <= addr_s;
            wdata_r <= wdata_s;
         end
      end
   end

   // Owner FIFO, outstanding count and the locally answered stkz read.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         fifo_r    <= {MaxOutstanding{1'b0}};
         rd_ptr_r  <= {PtrW{1'b0}};
         wr_ptr_r  <= {PtrW{1'b0}};
         cnt_r     <= {CntW{1'b0}};
         rd_pend_r <= 1'b0;
      end else begin
         rd_pend_r <= rd_acc_s;
         if (push_s) begin
            fifo_r[wr_ptr_r] <= owner_s;
            wr_ptr_r         <= ptr_inc(wr_ptr_r);
         end
         if (pop_s) begin
            rd_ptr_r <= ptr_inc(rd_ptr_r);
         end
         case ({push_s, pop_s})
            2'b10:   cnt_r <= cnt_r + CntW'(1);
            2'b01:   cnt_r <= cnt_r - CntW'(1);
            default: cnt_r <= cnt_r;
         endcase
      end
   end

endmodule

// File: tb/tb_cheri_stkz_lsu_arb.sv
// Directed and randomized bench for cheri_stkz_lsu_arb against a queue-based
// model of the arbitration, ownership order and response routing rules.
module tb_cheri_stkz_lsu_arb;

   localparam int MAX = 2;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        stkz_lsu_req_i, stkz_lsu_we_i, stkz_lsu_is_cap_i;
   logic [31:0] stkz_lsu_addr_i;
   logic [32:0] stkz_lsu_wdata_i;
   logic        lsu_stkz_req_done_o, lsu_stkz_resp_valid_o, lsu_stkz_resp_err_o;
   logic        core_req_i, core_we_i, core_is_cap_i;
   logic [31:0] core_addr_i;
   logic [32:0] core_wdata_i;
   logic        core_gnt_o, core_rvalid_o, core_err_o;
   logic [32:0] core_rdata_o;
   logic        data_req_o, data_we_o, data_is_cap_o;
   logic [31:0] data_addr_o;
   logic [32:0] data_wdata_o;
   logic        data_gnt_i, data_rvalid_i, data_err_i;
   logic [32:0] data_rdata_i;

   cheri_stkz_lsu_arb #(.MaxOutstanding(MAX)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .stkz_lsu_req_i(stkz_lsu_req_i), .stkz_lsu_we_i(stkz_lsu_we_i),
      .stkz_lsu_is_cap_i(stkz_lsu_is_cap_i), .stkz_lsu_addr_i(stkz_lsu_addr_i),
      .stkz_lsu_wdata_i(stkz_lsu_wdata_i),
      .lsu_stkz_req_done_o(lsu_stkz_req_done_o), .lsu_stkz_resp_valid_o(lsu_stkz_resp_valid_o),
      .lsu_stkz_resp_err_o(lsu_stkz_resp_err_o),
      .core_req_i(core_req_i), .core_we_i(core_we_i), .core_is_cap_i(core_is_cap_i),
      .core_addr_i(core_addr_i), .core_wdata_i(core_wdata_i),
      .core_gnt_o(core_gnt_o), .core_rvalid_o(core_rvalid_o), .core_err_o(core_err_o),
      .core_rdata_o(core_rdata_o),
      .data_req_o(data_req_o), .data_we_o(data_we_o), .data_is_cap_o(data_is_cap_o),
      .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
      .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i), .data_err_i(data_err_i),
      .data_rdata_i(data_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   int vectors = 0;
   int miscompares = 0;

   // Reference model: held request, owner queue (1 = stkz), pending local read.
   bit          hv, hown, hwe, hcap;
   bit [31:0]   haddr;
   bit [32:0]   hwdata;
   bit          mq[$];
   bit          rdpend;
   bit          m_present, m_owner, m_we, m_cap, m_fire, m_rdacc, m_pop;
   bit [31:0]   m_addr;
   bit [32:0]   m_wdata;

   task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs();
      core_req_i = 1'b0; core_we_i = 1'b0; core_is_cap_i = 1'b0;
      core_addr_i = 32'h0; core_wdata_i = 33'h0;
      stkz_lsu_req_i = 1'b0; stkz_lsu_we_i = 1'b0; stkz_lsu_is_cap_i = 1'b0;
      stkz_lsu_addr_i = 32'h0; stkz_lsu_wdata_i = 33'h0;
      data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_err_i = 1'b0; data_rdata_i = 33'h0;
   endtask

   task automatic predict_and_check();
      bit avail, head, e_crv, e_srv;
      avail = (mq.size() < MAX);
      m_present = 1'b0; m_owner = 1'b0; m_we = 1'b0; m_cap = 1'b0;
      m_addr = 32'h0; m_wdata = 33'h0;
      if (hv) begin
         m_present = 1'b1; m_owner = hown; m_we = hwe; m_cap = hcap;
         m_addr = haddr; m_wdata = hwdata;
      end else if (avail && core_req_i) begin
         m_present = 1'b1; m_owner = 1'b0; m_we = core_we_i; m_cap = core_is_cap_i;
         m_addr = core_addr_i; m_wdata = core_wdata_i;
      end else if (avail && stkz_lsu_req_i && stkz_lsu_we_i) begin
         m_present = 1'b1; m_owner = 1'b1; m_we = 1'b1; m_cap = stkz_lsu_is_cap_i;
         m_addr = stkz_lsu_addr_i; m_wdata = stkz_lsu_wdata_i;
      end
      m_rdacc = !hv && (mq.size() == 0) && !core_req_i && stkz_lsu_req_i && !stkz_lsu_we_i;
      m_fire  = m_present && data_gnt_i;
      m_pop   = data_rvalid_i && (mq.size() > 0);
      head    = (mq.size() > 0) ? mq[0] : 1'b0;
      e_crv   = m_pop && !head;
      e_srv   = (m_pop && head) || rdpend;
      chk("data_req",    data_req_o,    m_present);
      chk("data_we",     data_we_o,     m_we);
      chk("data_is_cap", data_is_cap_o, m_cap);
      chk("data_addr",   data_addr_o,   m_addr);
      chk("data_wdata",  data_wdata_o,  m_wdata);
      chk("core_gnt",    core_gnt_o,    m_fire && !m_owner);
      chk("stkz_done",   lsu_stkz_req_done_o, (m_fire && m_owner) || m_rdacc);
      chk("core_rvalid", core_rvalid_o, e_crv);
      chk("core_err",    core_err_o,    e_crv && data_err_i);
      chk("core_rdata",  core_rdata_o,  e_crv ? data_rdata_i : 33'h0);
      chk("stkz_rvalid", lsu_stkz_resp_valid_o, e_srv);
      chk("stkz_err",    lsu_stkz_resp_err_o, rdpend || (m_pop && head && data_err_i));
   endtask

   // One cycle: settle, check, clock, advance the model.
   task automatic step();
      bit dummy;
      #1;
      predict_and_check();
      @(posedge clk_i);
      if (m_pop) dummy = mq.pop_front();
      if (m_fire) begin
         mq.push_back(m_owner);
         hv = 1'b0;
      end else if (m_present && !hv) begin
         hv = 1'b1; hown = m_owner; hwe = m_we; hcap = m_cap;
         haddr = m_addr; hwdata = m_wdata;
      end
      rdpend = m_rdacc;
      #1;
   endtask

   task automatic apply_reset();
      clear_inputs();
      rst_ni = 1'b0;
      hv = 1'b0; rdpend = 1'b0; mq.delete();
      #1;
      predict_and_check();
      @(posedge clk_i);
      #1;
      predict_and_check();
      rst_ni = 1'b1;
      #1;
   endtask

   initial begin
      clear_inputs();
      rst_ni = 1'b1;
      #2;
      apply_reset();

      // Stkz write granted in the request cycle; bus response two cycles later.
      stkz_lsu_req_i = 1'b1; stkz_lsu_we_i = 1'b1; stkz_lsu_addr_i = 32'h0000_1FFC;
      stkz_lsu_wdata_i = 33'h0; data_gnt_i = 1'b1;
      step();
      clear_inputs();
      step();
      data_rvalid_i = 1'b1; data_err_i = 1'b0;
      step();
      clear_inputs();

      // Core and stkz together, grant delayed three cycles; stkz follows.
      core_req_i = 1'b1; core_we_i = 1'b1; core_addr_i = 32'hC0DE_0010; core_wdata_i = 33'h1_2345_6789;
      stkz_lsu_req_i = 1'b1; stkz_lsu_we_i = 1'b1; stkz_lsu_addr_i = 32'h0000_2000;
      step();
      core_addr_i = 32'hDEAD_BEEF;
      step();
      step();
      data_gnt_i = 1'b1;
      step();
      core_req_i = 1'b0;
      step();
      clear_inputs();
      data_rvalid_i = 1'b1; data_rdata_i = 33'h1_0000_00AA;
      step();
      data_err_i = 1'b1;
      step();
      clear_inputs();

      // Fill the outstanding limit, then request with grant held high.
      stkz_lsu_req_i = 1'b1; stkz_lsu_we_i = 1'b1; stkz_lsu_addr_i = 32'h100; data_gnt_i = 1'b1;
      step();
      stkz_lsu_addr_i = 32'h104;
      step();
      stkz_lsu_addr_i = 32'h108;
      step();
      step();
      data_rvalid_i = 1'b1;
      step();
      step();
      data_rvalid_i = 1'b0;
      step();
      step();
      clear_inputs();
      data_rvalid_i = 1'b1;
      step();
      step();
      clear_inputs();

      // Core grant then stkz grant; responses err 0 then 1.
      core_req_i = 1'b1; core_addr_i = 32'h40; data_gnt_i = 1'b1;
      step();
      core_req_i = 1'b0; stkz_lsu_req_i = 1'b1; stkz_lsu_we_i = 1'b1; stkz_lsu_addr_i = 32'h80;
      step();
      clear_inputs();
      data_rvalid_i = 1'b1; data_err_i = 1'b0; data_rdata_i = 33'h0_5555_AAAA;
      step();
      data_err_i = 1'b1;
      step();
      clear_inputs();

      // Stkz held, requester drops and changes; then reset mid-hold.
      stkz_lsu_req_i = 1'b1; stkz_lsu_we_i = 1'b1; stkz_lsu_is_cap_i = 1'b1;
      stkz_lsu_addr_i = 32'h3000; stkz_lsu_wdata_i = 33'h1_FFFF_0000;
      step();
      stkz_lsu_req_i = 1'b0; stkz_lsu_addr_i = 32'h9999;
      step();
      step();
      apply_reset();

      // Response with nothing outstanding, and a local stkz read.
      data_rvalid_i = 1'b1; data_err_i = 1'b1; data_rdata_i = 33'h1_2222_3333;
      step();
      clear_inputs();
      stkz_lsu_req_i = 1'b1; stkz_lsu_we_i = 1'b0;
      step();
      clear_inputs();
      step();

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         core_req_i        = ($urandom_range(0, 2) == 0);
         core_we_i         = $urandom_range(0, 1);
         core_is_cap_i     = $urandom_range(0, 1);
         core_addr_i       = $urandom;
         core_wdata_i      = {1'($urandom_range(0, 1)), 32'($urandom)};
         stkz_lsu_req_i    = ($urandom_range(0, 1) == 0);
         stkz_lsu_we_i     = ($urandom_range(0, 3) != 0);
         stkz_lsu_is_cap_i = $urandom_range(0, 1);
         stkz_lsu_addr_i   = $urandom;
         stkz_lsu_wdata_i  = {1'($urandom_range(0, 1)), 32'($urandom)};
         data_gnt_i        = $urandom_range(0, 1);
         data_rvalid_i     = ($urandom_range(0, 4) < 2);
         data_err_i        = $urandom_range(0, 1);
         data_rdata_i      = {1'($urandom_range(0, 1)), 32'($urandom)};
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
